// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: arbitrates ALU and load writebacks onto the single register-bank write port
module regbank_write_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    rd,
  output logic [DATA_W-1:0]    dataToWrite,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic [2:0]           starve_cnt
);
  localparam int N = 2**ADDR_W;
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  localparam logic [N-1:0] ONE = N'(1);
  typedef enum logic {PRI_MEM, PRI_ALU} state_t;
  state_t state, state_nxt;
  logic [2:0] cnt_nxt;
  logic lose;
  always_comb begin
    alu_ready = alu_valid & (state == PRI_ALU | ~mem_valid);
    mem_ready = mem_valid & ~alu_ready;
    lose      = alu_valid & ~alu_ready;
    cnt_nxt   = lose ? (starve_cnt == SMAX ? starve_cnt : starve_cnt + 3'd1) : 3'd0;
    state_nxt = alu_ready ? PRI_MEM : (lose && starve_cnt + 3'd1 == SMAX) ? PRI_ALU : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= PRI_MEM;
      starve_cnt <= 3'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  // rd/data hold their last value on idle cycles
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      RegWrite    <= 1'b0;
      rd          <= '0;
      dataToWrite <= '0;
    end else begin
      RegWrite <= alu_ready | mem_ready;
      if (alu_ready | mem_ready) begin
        rd          <= alu_ready ? alu_rd : mem_rd;
        dataToWrite <= alu_ready ? alu_data : mem_data;
      end
    end
  always_comb
    pending_mask = (alu_valid ? ONE << alu_rd : '0) |
                   (mem_valid ? ONE << mem_rd : '0) |
                   (RegWrite  ? ONE << rd     : '0);
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed-vector bench for regbank_write_arbiter
module tb_regbank_write_arbiter;
  logic clock = 0, reset = 1;
  logic alu_valid = 0, mem_valid = 0;
  logic [2:0] alu_rd = 0, mem_rd = 0, rd;
  logic [15:0] alu_data = 0, mem_data = 0, dataToWrite;
  logic alu_ready, mem_ready, RegWrite;
  logic [7:0] pending_mask;
  logic [2:0] starve_cnt;
  int total = 0, bad = 0;
  int cnt_e[5] = '{0, 1, 2, 3, 0};

  regbank_write_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWrite(RegWrite), .rd(rd), .dataToWrite(dataToWrite),
    .pending_mask(pending_mask), .starve_cnt(starve_cnt)
  );

  always #5 clock = ~clock;

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task step;
    @(posedge clock);
    #1;
  endtask

  task port(input string tag, input logic we, input logic [2:0] r, input logic [15:0] d);
    chk({tag, "_we"}, RegWrite, we);
    chk({tag, "_rd"}, rd, r);
    chk({tag, "_data"}, dataToWrite, d);
  endtask

  initial begin
    #2;
    port("rst", 0, 0, 0);
    chk("rst_pm", pending_mask, 8'h00);
    chk("rst_cnt", starve_cnt, 0);
    #10 reset = 0;
    step;
    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 16'h1234;
    #2;
    chk("alu1_ready", alu_ready, 1);
    chk("alu1_mready", mem_ready, 0);
    chk("alu1_pm0", pending_mask, 8'h20);
    step; alu_valid = 0; #2;
    port("alu1", 1, 5, 16'h1234);
    chk("alu1_pm1", pending_mask, 8'h20);
    step; #2;
    port("alu1_idle", 0, 5, 16'h1234);
    chk("alu1_pm2", pending_mask, 8'h00);
    // simultaneous requests, mem wins first
    step;
    alu_valid = 1; alu_rd = 2; alu_data = 16'hAAAA;
    mem_valid = 1; mem_rd = 3; mem_data = 16'h5555;
    #2;
    chk("sim0_mready", mem_ready, 1);
    chk("sim0_aready", alu_ready, 0);
    chk("sim0_cnt", starve_cnt, 0);
    chk("sim0_pm", pending_mask, 8'h0C);
    step; mem_valid = 0; #2;
    chk("sim1_aready", alu_ready, 1);
    chk("sim1_cnt", starve_cnt, 1);
    port("sim1", 1, 3, 16'h5555);
    step; alu_valid = 0; #2;
    chk("sim2_cnt", starve_cnt, 0);
    port("sim2", 1, 2, 16'hAAAA);
    // starvation: ALU forced through on the fourth cycle
    step;
    alu_valid = 1; alu_rd = 1; alu_data = 16'h00A1;
    mem_valid = 1; mem_rd = 6;
    for (int c = 0; c < 5; c++) begin
      mem_data = 16'h0100 + 16'(c);
      #2;
      chk($sformatf("stv%0d_aready", c), alu_ready, c == 3);
      chk($sformatf("stv%0d_mready", c), mem_ready, c != 3);
      chk($sformatf("stv%0d_cnt", c), starve_cnt, cnt_e[c]);
      if (c == 4) port("stv4", 1, 1, 16'h00A1);
      else if (c > 0) port($sformatf("stv%0d", c), 1, 6, 16'h0100 + 16'(c - 1));
      step;
    end
    alu_valid = 0; mem_valid = 0; #2;
    port("stv_end", 1, 6, 16'h0104);
    chk("stv_end_cnt", starve_cnt, 1);
    step;
    // same-rd collision: mem first, ALU data lands last
    alu_valid = 1; alu_rd = 4; alu_data = 16'h0001;
    mem_valid = 1; mem_rd = 4; mem_data = 16'h0002;
    #2;
    chk("col0_mready", mem_ready, 1);
    chk("col0_pm", pending_mask, 8'h10);
    step; mem_valid = 0; #2;
    chk("col1_aready", alu_ready, 1);
    port("col1", 1, 4, 16'h0002);
    chk("col1_pm", pending_mask, 8'h10);
    step; alu_valid = 0; #2;
    port("col2", 1, 4, 16'h0001);
    chk("col2_pm", pending_mask, 8'h10);
    step; #2;
    chk("col3_we", RegWrite, 0);
    chk("col3_pm", pending_mask, 8'h00);
    // drive into PRI_ALU, then reset while a mem write is in flight
    alu_valid = 1; alu_rd = 0; alu_data = 16'h0F0F;
    mem_valid = 1; mem_rd = 7; mem_data = 16'hBEEF;
    step; step; step;
    alu_valid = 0; mem_valid = 0; #1;
    chk("rmid_cnt", starve_cnt, 3);
    port("rmid_pre", 1, 7, 16'hBEEF);
    reset = 1; #1;
    port("rmid", 0, 0, 0);
    chk("rmid_cnt0", starve_cnt, 0);
    chk("rmid_pm", pending_mask, 8'h00);
    reset = 0;
    alu_valid = 1; mem_valid = 1; mem_data = 16'hCAFE; #1;
    chk("rmid_mready", mem_ready, 1);
    chk("rmid_aready", alu_ready, 0);
    chk("rmid_pm2", pending_mask, 8'h81);
    step; alu_valid = 0; mem_valid = 0; #2;
    port("rmid_post", 1, 7, 16'hCAFE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the single write port of the 8 x 16-bit register bank between two writeback requesters: the ALU result path and the memory-load path.
- Each requester uses a valid/ready handshake; the winner is registered onto the bank's write port.
- Memory has fixed priority; a starvation counter forces an ALU grant after repeated losses.
- Also exports a pending-write mask so the decode stage can stall on register hazards.

Parameters:
- DATA_W, 16, width of the write data.
- ADDR_W, 3, width of a register index (bank depth = 2^ADDR_W = 8).
- STARVE_MAX, 3, number of consecutive ALU losses after which the ALU is granted unconditionally; legal range 1..7.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- alu_ready  output  1  ALU request accepted this cycle (combinational).
- mem_valid  input  1  load writeback request.
- mem_rd  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- mem_ready  output  1  load request accepted this cycle (combinational).
- RegWrite  output  1  write enable to the register bank (registered).
- rd  output  ADDR_W  write index to the register bank (registered).
- dataToWrite  output  DATA_W  write data to the register bank (registered).
- pending_mask  output  2^ADDR_W  bit i = 1 when a write to register i is requested or in flight.
- starve_cnt  output  3  current consecutive-ALU-loss count (debug/visibility).

Behaviour:
- Reset (async, any time):
  - RegWrite=0, rd=0, dataToWrite=0, starve_cnt=0, state=PRI_MEM.
  - pending_mask then reflects only the live valid inputs.
  - An in-flight write is dropped; it is never replayed.
- States:
  - PRI_MEM (default): if mem_valid, grant mem; else if alu_valid, grant alu.
  - PRI_ALU: if alu_valid, grant alu; else if mem_valid, grant mem.
  - PRI_MEM -> PRI_ALU when a cycle ends with alu_valid=1, not granted, and starve_cnt+1 == STARVE_MAX.
  - PRI_ALU -> PRI_MEM on the cycle the ALU is granted.
- starve_cnt:
  - Increments when alu_valid=1 and the ALU is not granted.
  - Clears to 0 when the ALU is granted or alu_valid=0.
  - Saturates at STARVE_MAX.
- Grant rules:
  - At most one grant per cycle.
  - alu_ready/mem_ready are combinational from the valids and state, never asserted without the matching valid.
  - The port is always free, so one requester with valid=1 is granted the same cycle.
- Latency: a request accepted in cycle N drives RegWrite=1, rd, and dataToWrite during cycle N+1, so the bank's write samples it on the negedge of N+1.
- No grant in cycle N -> RegWrite=0 in N+1; rd and dataToWrite hold their previous values.
- Requesters hold rd and data stable while valid=1 and ready=0; dropping valid without ready is allowed (request withdrawn).
- Same-rd collision (alu_rd == mem_rd, both valid): the winner writes first and the loser next. Final register value = loser's data, consistent with the loser being the younger writeback.
- pending_mask = (alu_valid ? onehot(alu_rd) : 0) | (mem_valid ? onehot(mem_rd) : 0) | (RegWrite ? onehot(rd) : 0).
  - Combinational.
  - Register 0 is an ordinary writable register and is masked like any other.
- Back-to-back grants every cycle are supported; sustained throughput is 1 write/cycle.

Test Plan:
- Reset then idle: assert reset mid-cycle, both valids 0 -> RegWrite=0, rd=0, dataToWrite=0, pending_mask=0x00 immediately (async), starve_cnt=0.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> alu_ready=1 same cycle; next cycle RegWrite=1, rd=5, dataToWrite=0x1234; pending_mask=0x20 both cycles; cycle after, RegWrite=0.
- Simultaneous requests: alu rd=2/0xAAAA, mem rd=3/0x5555 held valid -> cycle 0 mem_ready=1; cycle 1 alu_ready=1; port shows (3,0x5555) then (2,0xAAAA); starve_cnt goes 0->1->0.
- Starvation: STARVE_MAX=3, mem_valid held 1 continuously, alu_valid held 1 -> mem granted cycles 0-2, starve_cnt 1,2,3; ALU granted cycle 3; mem granted again from cycle 4.
- Same-rd collision: alu rd=4/0x0001, mem rd=4/0x0002 both valid -> writes (4,0x0002) then (4,0x0001); pending_mask bit 4 set until the second write's RegWrite cycle ends.
- Reset mid-operation: grant mem in cycle N, assert reset during N+1 -> RegWrite falls to 0 asynchronously, state returns to PRI_MEM, starve_cnt=0; after release, a fresh mem_valid is granted the same cycle.
